// File: rtl/system_stream_buffer.sv
// Elastic byte FIFO between the Ethernet receiver and the system-stream parser,
// presenting a 4-byte MSB-first look-ahead window for start-code detection.
module system_stream_buffer #(
  parameter int DEPTH_LOG2   = 9,
  parameter int AFULL_MARGIN = 64
) (
  input  logic                resetn,
  input  logic                clock,
  input  logic                Flush_I,
  input  logic [7:0]          Rx_Data_I,
  input  logic                Rx_Write_En_I,
  output logic                Rx_Full_O,
  output logic                Rx_Almost_Full_O,
  output logic                Rx_Overflow_O,
  output logic [DEPTH_LOG2:0] Fill_Level_O,
  input  logic                Shift_8_En_I,
  output logic                System_Buffer_Empty_O,
  output logic [31:0]         Bitstream_Data_O
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_C   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE_C = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE_C = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [31:0]           window_q, window_d;
  logic [2:0]            win_cnt_q, win_cnt_d;
  logic                  overflow_q, overflow_d;
  logic                  full_s, wr_s, acc_s, pop_s;
  logic [7:0]            rd_data_s;

  assign full_s    = (count_q == DEPTH_C);
  assign wr_s      = Rx_Write_En_I & ~full_s & ~Flush_I;
  assign acc_s     = Shift_8_En_I & (win_cnt_q == 3'd4);
  assign pop_s     = (count_q != {(DEPTH_LOG2+1){1'b0}}) & ((win_cnt_q < 3'd4) | acc_s);
  assign rd_data_s = mem_q[rd_ptr_q];

  // Next-state for pointers, count, window and overflow; flush overrides everything.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    window_d   = window_q;
    win_cnt_d  = win_cnt_q;
    overflow_d = overflow_q;
    if (Flush_I) begin
      wr_ptr_d   = {DEPTH_LOG2{1'b0}};
      rd_ptr_d   = {DEPTH_LOG2{1'b0}};
      count_d    = {(DEPTH_LOG2+1){1'b0}};
      window_d   = 32'h0000_0000;
      win_cnt_d  = 3'd0;
      overflow_d = 1'b0;
    end else begin
      if (wr_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE_C;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (Rx_Write_En_I & full_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
      case ({wr_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE_C;
        2'b01:   count_d = count_q - CNT_ONE_C;
        default: count_d = count_q;
      endcase
      // A shift with nothing to pop leaves a zero-filled hole and drops to 3 valid bytes.
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE_C;
        window_d = {window_q[23:0], rd_data_s};
        if (win_cnt_q < 3'd4) begin
          win_cnt_d = win_cnt_q + 3'd1;
        end else begin
          win_cnt_d = win_cnt_q;
        end
      end else if (acc_s) begin
        window_d  = {window_q[23:0], 8'h00};
        win_cnt_d = 3'd3;
      end else begin
        window_d  = window_q;
        win_cnt_d = win_cnt_q;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= {DEPTH_LOG2{1'b0}};
      rd_ptr_q   <= {DEPTH_LOG2{1'b0}};
      count_q    <= {(DEPTH_LOG2+1){1'b0}};
      window_q   <= 32'h0000_0000;
      win_cnt_q  <= 3'd0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      window_q   <= window_d;
      win_cnt_q  <= win_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Distributed RAM: registered write, asynchronous read at the read pointer.
  always_ff @(posedge clock) begin
    if (wr_s) begin
      mem_q[wr_ptr_q] <= Rx_Data_I;
    end
  end

  assign Rx_Full_O             = full_s;
  assign Rx_Almost_Full_O      = ((DEPTH - int'(count_q)) <= AFULL_MARGIN);
  assign Rx_Overflow_O         = overflow_q;
  assign Fill_Level_O          = count_q;
  assign System_Buffer_Empty_O = (win_cnt_q != 3'd4);
  assign Bitstream_Data_O      = window_q;

endmodule

// File: doc/system_stream_buffer.md
# system_stream_buffer

Byte-wide elastic buffer between the Ethernet receive path and the system-stream parser. It accepts demultiplexer-bound MPEG-2 program-stream bytes from the Ethernet receiver and stores them in an on-chip FIFO. It presents a 4-byte, MSB-first look-ahead window to the parser, which uses the window to detect start codes, and advances the window one byte per parser shift request.

## Interface

- DEPTH_LOG2, 9: FIFO depth is 2^DEPTH_LOG2 bytes (default 512).
- AFULL_MARGIN, 64: `Rx_Almost_Full_O` asserts when free FIFO entries are at most this value.
- resetn  input  1  asynchronous, active-low reset.
- clock  input  1  system clock; all logic is on its rising edge.
- Flush_I  input  1  synchronous flush of the FIFO, the window and the overflow flag.
- Rx_Data_I  input  8  incoming stream byte.
- Rx_Write_En_I  input  1  writes `Rx_Data_I` this cycle.
- Rx_Full_O  output  1  FIFO holds 2^DEPTH_LOG2 bytes.
- Rx_Almost_Full_O  output  1  free entries are at most AFULL_MARGIN.
- Rx_Overflow_O  output  1  sticky flag: a write was attempted while full.
- Fill_Level_O  output  DEPTH_LOG2+1  bytes currently in the FIFO; excludes window bytes.
- Shift_8_En_I  input  1  parser request to discard the window's oldest byte.
- System_Buffer_Empty_O  output  1  window does not hold 4 valid bytes.
- Bitstream_Data_O  output  32  window; [31:24] is the oldest byte, [7:0] the newest.

## Operation

- Storage: 2^DEPTH_LOG2 × 8 RAM with a registered write and an asynchronous read at the read pointer (distributed RAM).
- Pointers: write and read pointers are DEPTH_LOG2 bits and wrap modulo depth. The count is a separate DEPTH_LOG2+1-bit register.
- Write: `wr = Rx_Write_En_I & ~Rx_Full_O & ~Flush_I`. A write attempted while full is dropped, and `Rx_Overflow_O` is set.
- Window: a 32-bit register plus `win_cnt` (0..4). `System_Buffer_Empty_O = (win_cnt != 4)`.
- Shift accepted: `acc = Shift_8_En_I & (win_cnt == 4)`. A shift request while empty is ignored and produces no state change.
- Pop: `pop = (count != 0) & ((win_cnt < 4) | acc)`.
- Window update, per cycle:
  - pop: window <= {window[23:0], ram[rd_ptr]}; `win_cnt` increments if below 4, otherwise it stays at 4.
  - acc without pop: window <= {window[23:0], 8'h00}; `win_cnt` <= 3.
  - otherwise: window holds.
- Count update: count <= count + wr − pop. A simultaneous write and pop leaves the count unchanged.
- No bypass path: a byte written into an empty FIFO is poppable one cycle after its write edge.
- Flush has priority over all other activity. On the next edge it clears both pointers, count, window, `win_cnt` and `Rx_Overflow_O`. The write and shift presented in the flush cycle are dropped.
- Flags: `Rx_Full_O = (count == 2^DEPTH_LOG2)`; `Rx_Almost_Full_O = (2^DEPTH_LOG2 − count <= AFULL_MARGIN)`. Both are combinational from the count register.

## Timing

- Reset values:
  - `Bitstream_Data_O` = 0, `System_Buffer_Empty_O` = 1.
  - `Rx_Full_O` = 0, `Rx_Almost_Full_O` = 0 for depth > AFULL_MARGIN.
  - `Rx_Overflow_O` = 0, `Fill_Level_O` = 0.
  - Pointers, count and `win_cnt` are 0.
- Reset mid-operation discards all content immediately (asynchronous).
- Latency from write edge to window entry: 1 cycle when the window is not full.
- Priming from empty: bytes written at edges 0..3 enter the window at edges 1..4. `System_Buffer_Empty_O` falls after edge 4.
- Streaming: with a full window and FIFO count ≥ 1, `Shift_8_En_I` held high advances one byte per cycle and empty stays low.
- Underflow: with a full window and FIFO count 0, an accepted shift makes `win_cnt` 3 and empty rises after that edge. A byte present in the FIFO on a later edge refills the window one edge later.
- Outputs change only on clock edges, except the flags, which are combinational decodes of the count register.
- Sustained throughput is 1 byte/cycle in and 1 byte/cycle out.

## Test plan

- Reset, then write 00,00,01,BA on consecutive cycles → `Bitstream_Data_O` = 0x000001BA and empty deasserts after the 4th post-write edge; `Fill_Level_O` = 0.
- Prime with 00 00 01 E0 07 EC, then hold the shift high for 2 cycles → window reads 0x0001E007, then 0x01E007EC. A third shift with the FIFO empty gives 0xE007EC00 with empty = 1, and further shifts leave the window unchanged.
- DEPTH_LOG2 = 4, AFULL_MARGIN = 2, no shifts: write 20 bytes 0x00..0x13 → window 0x00010203 and FIFO holds 0x04..0x13. `Rx_Almost_Full_O` rises at fill level 14, `Rx_Full_O` at 16, and `Rx_Overflow_O` sets on the 21st write. Then shift 16 times → window 0x10111213 with no byte lost or duplicated.
- Simultaneous write and shift at full window, count = 5, for 100 cycles with an incrementing pattern → count stays 5 and the output byte sequence is contiguous across pointer wrap.
- Assert Flush_I while streaming with overflow set → next cycle: empty = 1, data = 0, `Fill_Level_O` = 0, overflow = 0. The byte written in the flush cycle is absent from the stream.
- Deassert resetn asynchronously mid-stream → all outputs take their reset values before the next clock edge, and re-priming behaves as in the first scenario.
